// File: rtl/cnn_sweep_ctrl.sv
// Sweep sequencer for the single-cell CNN datapath: gathers 3x3 Y/U windows and writes results to the opposite Y bank.
// Define EDGE_CLAMP_EN to replicate edge cells at the grid boundary instead of zero-filling.
module cnn_sweep_ctrl #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        iter_count,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  input  logic [8:0]        rd_y,
  input  logic [7:0]        rd_u,
  output logic [80:0]       win_y,
  output logic [71:0]       win_u,
  input  logic [8:0]        dp_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [8:0]        wr_data,
  output logic              result_bank
);

`ifdef EDGE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(GRID_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EVAL, WRITE, FIN} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] row, col;
  logic [3:0]        k;
  logic [7:0]        iter, iter_max;
  logic              bank, result_q;
  logic [8:0][8:0]   wy;
  logic [8:0][7:0]   wu;
  logic [8:0]        wr_q;
  logic              cap_vld, cap_in;
  logic [3:0]        cap_slot;

  logic [1:0]        dy, dx;
  logic [ADDR_W-1:0] nrow, ncol, nb_addr, centre_addr;
  logic              in_grid, last_cell;

  // Neighbour coordinates for slot k; out-of-grid slots either zero-fill or clamp.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    dy      = 2'd1;
    dx      = 2'd1;
    nrow    = row;
    ncol    = col;
    in_grid = 1'b1;
    case (k)
      4'd0:    {dy, dx} = 4'b00_00;
      4'd1:    {dy, dx} = 4'b00_01;
      4'd2:    {dy, dx} = 4'b00_10;
      4'd3:    {dy, dx} = 4'b01_00;
      4'd5:    {dy, dx} = 4'b01_10;
      4'd6:    {dy, dx} = 4'b10_00;
      4'd7:    {dy, dx} = 4'b10_01;
      4'd8:    {dy, dx} = 4'b10_10;
      default: {dy, dx} = 4'b01_01;
    endcase
    if (dy == 2'd0) begin
      if (row != '0) nrow = row - 1'b1;
      else if (!CLAMP) in_grid = 1'b0;
    end else if (dy == 2'd2) begin
      if (row != LAST_ROW) nrow = row + 1'b1;
      else if (!CLAMP) in_grid = 1'b0;
    end
    if (dx == 2'd0) begin
      if (col != '0) ncol = col - 1'b1;
      else if (!CLAMP) in_grid = 1'b0;
    end else if (dx == 2'd2) begin
      if (col != LAST_COL) ncol = col + 1'b1;
      else if (!CLAMP) in_grid = 1'b0;
    end
  end

  assign nb_addr     = nrow * W_A + ncol;
  assign centre_addr = row * W_A + col;
  assign last_cell   = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (iter_count == 8'd0) ? FIN : FETCH;
      FETCH:   if (k == 4'd8) next_state = WAIT;
      WAIT:    next_state = EVAL;
      EVAL:    next_state = WRITE;
      WRITE:   if (last_cell && (iter + 8'd1 == iter_max)) next_state = FIN;
               else next_state = FETCH;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counters, window capture and result register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the window is a small register file, so clearing it on reset is cheap and keeps win_y/win_u defined.
    if (rst) begin
      row      <= '0;
      col      <= '0;
      k        <= '0;
      iter     <= '0;
      iter_max <= '0;
      bank     <= 1'b0;
      result_q <= 1'b0;
      wy       <= '0;
      wu       <= '0;
      wr_q     <= '0;
      cap_vld  <= 1'b0;
      cap_in   <= 1'b0;
      cap_slot <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      cap_vld  <= (state == FETCH);
      cap_slot <= k;
      cap_in   <= in_grid;
      if (cap_vld) begin
        wy[cap_slot] <= cap_in ? rd_y : 9'd0;
        wu[cap_slot] <= cap_in ? rd_u : 8'd0;
      end
      case (state)
        IDLE: if (start) begin
          iter_max <= iter_count;
          row      <= '0;
          col      <= '0;
          k        <= '0;
          iter     <= '0;
        end
        FETCH: k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
        EVAL:  wr_q <= dp_out;
        WRITE: begin
          if (last_cell) begin
            row  <= '0;
            col  <= '0;
            iter <= iter + 8'd1;
            bank <= ~bank;
          end else if (col == LAST_COL) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        FIN:     result_q <= bank;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    result_bank = result_q;
    case (state)
      FETCH: begin
        busy    = 1'b1;
        rd_en   = in_grid;
        rd_addr = in_grid ? nb_addr : '0;
      end
      WAIT, EVAL: busy = 1'b1;
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = centre_addr;
      end
      FIN: begin
        done        = 1'b1;
        result_bank = bank;
      end
      default: ;
    endcase
  end

  assign rd_bank = bank;
  assign wr_bank = ~bank;
  assign wr_data = wr_q;
  assign win_y   = wy;
  assign win_u   = wu;

endmodule

// File: tb/tb_cnn_sweep_ctrl.sv
// Directed bench for cnn_sweep_ctrl on a 3x3 grid with an addr-echo memory model.
module tb_cnn_sweep_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    iter_count;
  logic          busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [8:0]    rd_y, dp_out, wr_data;
  logic [7:0]    rd_u;
  logic [80:0]   win_y;
  logic [71:0]   win_u;

  cnn_sweep_ctrl #(.GRID_W(3), .GRID_H(3), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .iter_count(iter_count),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .rd_y(rd_y), .rd_u(rd_u), .win_y(win_y), .win_u(win_u), .dp_out(dp_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
    .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  // Memory: Y echoes the address, U is address+16, one cycle latency.
  initial begin rd_y = '0; rd_u = '0; end
  always @(posedge clk) if (rd_en) begin
    rd_y <= 9'(rd_addr);
    rd_u <= 8'(rd_addr) + 8'd16;
  end

  typedef struct {
    logic       en;
    logic [3:0] addr;
    logic [8:0] y;
    logic [7:0] u;
  } fetch_vec_t;

  fetch_vec_t cell0 [9];

  int n_cmp = 0, n_fail = 0;
  int n, busy_cnt, wr_cnt, rd_cnt, done_cnt, done_n;
  logic prev_wr, done_after_wr;
  logic       wr_bank_log [64];
  logic [3:0] wr_addr_log [64];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic fetch_vec_t mk(input logic en, input logic [3:0] addr);
    fetch_vec_t v;
    v.en   = en;
    v.addr = addr;
    v.y    = en ? 9'(addr) : 9'd0;
    v.u    = en ? 8'(addr) + 8'd16 : 8'd0;
    return v;
  endfunction

  task automatic clear_counts();
    n = -1; busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_n = -1;
    prev_wr = 1'b0; done_after_wr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (busy) busy_cnt++;
    if (rd_en) rd_cnt++;
    if (wr_en) begin
      if (wr_cnt < 64) begin
        wr_bank_log[wr_cnt] = wr_bank;
        wr_addr_log[wr_cnt] = wr_addr;
      end
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_n = n;
      done_after_wr = prev_wr;
    end
    prev_wr = wr_en;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_wr_bank"}, wr_bank, 1);
    check({tag, "_result_bank"}, result_bank, 0);
    check({tag, "_win_y"}, win_y, 0);
    check({tag, "_win_u"}, win_u, 0);
  endtask

  // Starts a run and steps until done or budget; detail=1 adds cell-level checks on a 1-iteration run.
  task automatic do_run(input logic [7:0] cnt, input bit detail, input int budget);
    clear_counts();
    iter_count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    iter_count = 8'hFF;
    while (done_cnt == 0 && n < budget) begin
      start = 1'b0;
      if (detail) begin
        if (n < 9) begin
          check($sformatf("c0_rd_en_k%0d", n), rd_en, cell0[n].en);
          if (cell0[n].en) check($sformatf("c0_rd_addr_k%0d", n), rd_addr, cell0[n].addr);
        end
        if (n == 10) for (int s = 0; s < 9; s++) begin
          check($sformatf("c0_win_y%0d", s), win_y[s*9 +: 9], cell0[s].y);
          check($sformatf("c0_win_u%0d", s), win_u[s*8 +: 8], cell0[s].u);
        end
        if (n == 20) start = 1'b1;
        if (n == 58) for (int s = 0; s < 9; s++) begin
          check($sformatf("c4_win_y%0d", s), win_y[s*9 +: 9], 9'(s));
          check($sformatf("c4_win_u%0d", s), win_u[s*8 +: 8], 8'(s + 16));
        end
        if (n == 59) begin
          check("c4_wr_en", wr_en, 1);
          check("c4_wr_addr", wr_addr, 4);
          check("c4_wr_data", wr_data, 9'h1FB);
        end
      end
      tick();
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int ok;
    cell0[0] = mk(`ifdef EDGE_CLAMP_EN 1'b1 `else 1'b0 `endif, 4'd0);
    cell0[1] = mk(`ifdef EDGE_CLAMP_EN 1'b1 `else 1'b0 `endif, 4'd0);
    cell0[2] = mk(`ifdef EDGE_CLAMP_EN 1'b1 `else 1'b0 `endif, 4'd1);
    cell0[3] = mk(`ifdef EDGE_CLAMP_EN 1'b1 `else 1'b0 `endif, 4'd0);
    cell0[4] = mk(1'b1, 4'd0);
    cell0[5] = mk(1'b1, 4'd1);
    cell0[6] = mk(`ifdef EDGE_CLAMP_EN 1'b1 `else 1'b0 `endif, 4'd3);
    cell0[7] = mk(1'b1, 4'd3);
    cell0[8] = mk(1'b1, 4'd4);

    rst = 1'b1; start = 1'b0; iter_count = 8'd0; dp_out = 9'h1FB;
    clear_counts();
    tick(); tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Zero iterations: straight to FIN.
    do_run(8'd0, 1'b0, 20);
    check("it0_done_n", done_n, 0);
    check("it0_result_bank", result_bank, 0);
    repeat (4) tick();
    check("it0_rd_cnt", rd_cnt, 0);
    check("it0_wr_cnt", wr_cnt, 0);

    // One iteration with cell-level checks and a start pulse mid-run.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    do_run(8'd1, 1'b1, 400);
    check("it1_busy_cycles", busy_cnt, 108);
    check("it1_done_n", done_n, 108);
    check("it1_done_after_wr", done_after_wr, 1);
    check("it1_result_bank", result_bank, 1);
    check("it1_wr_cnt", wr_cnt, 9);
    check("it1_rd_cnt", rd_cnt, `ifdef EDGE_CLAMP_EN 81 `else 49 `endif);
    ok = 0;
    for (int i = 0; i < 9; i++) if (wr_bank_log[i] == 1'b1 && wr_addr_log[i] == 4'(i)) ok++;
    check("it1_wr_order", ok, 9);
    tick();
    check("it1_done_pulse_len", done, 0);

    // Two iterations: banks alternate, final result in bank 0.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    dp_out = 9'd37;
    do_run(8'd2, 1'b0, 600);
    check("it2_busy_cycles", busy_cnt, 216);
    check("it2_wr_cnt", wr_cnt, 18);
    check("it2_result_bank", result_bank, 0);
    check("it2_wr_data", wr_data, 9'd37);
    ok = 0;
    for (int i = 0; i < 18; i++) if (wr_bank_log[i] == (i < 9)) ok++;
    check("it2_bank_order", ok, 18);

    // Abort at the 5th FETCH cycle of cell 2, then rerun cleanly.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    dp_out = 9'h1FB;
    clear_counts();
    iter_count = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (28) tick();
    check("abort_rd_en", rd_en, 1);
    check("abort_rd_addr", rd_addr, 2);
    check("abort_wr_data_pre", wr_data, 9'h1FB);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    clear_counts();
    repeat (30) tick();
    check("abort_no_wr", wr_cnt, 0);
    check("abort_no_rd", rd_cnt, 0);
    do_run(8'd1, 1'b0, 400);
    check("rerun_busy_cycles", busy_cnt, 108);
    check("rerun_first_wr_addr", wr_addr_log[0], 0);
    check("rerun_first_wr_bank", wr_bank_log[0], 1);
    check("rerun_result_bank", result_bank, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
